qconv_mac_engine: RTL and testbench

QCONV_MAC_ENGINE -- requirements
Module: qconv_mac_engine

---
 rtl/qconv_mac_engine.sv | 127 ++++++++++++
 tb/tb_qconv_mac_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qconv_mac_engine.sv
// rtl/qconv_mac_engine.sv - Q-format dot-product MAC with bias, round-half-up, saturation and optional ReLU
module qconv_mac_engine #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int MAX_TAPS   = 72,
   localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(MAX_TAPS) + 1,
   localparam int CNT_WIDTH = $clog2(MAX_TAPS+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_x,
   input  logic [DATA_WIDTH-1:0] in_w,
   input  logic                  in_last,
   input  logic [DATA_WIDTH-1:0] cfg_bias,
   input  logic                  cfg_relu,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_sat,
   output logic                  out_ovf,
   output logic [CNT_WIDTH-1:0]  out_taps
);

   localparam int SUM_WIDTH = ACC_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TAPS);

   typedef enum logic [1:0] {ACCUM, ROUND, HOLD} state_t;

   state_t                         state;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic [CNT_WIDTH-1:0]           cnt;
   logic                           ovf;
   logic [DATA_WIDTH-1:0]          bias_q;
   logic                           relu_q;

   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [ACC_WIDTH-1:0]    prod_ext;
   logic signed [SUM_WIDTH-1:0]    acc_ext;
   logic signed [SUM_WIDTH-1:0]    bias_ext;
   logic signed [SUM_WIDTH-1:0]    half;
   logic signed [SUM_WIDTH-1:0]    sum;
   logic signed [SUM_WIDTH-1:0]    shifted;
   logic                           hi_pos;
   logic                           hi_neg;
   logic [DATA_WIDTH-1:0]          res;
   logic                           sat_c;

   assign in_ready = (state == ACCUM);
   assign prod     = $signed(in_x) * $signed(in_w);
   assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

   // Rounding datapath: one guard bit above the accumulator keeps the bias/half add exact.
   always_comb begin
      acc_ext  = {acc[ACC_WIDTH-1], acc};
      bias_ext = {{(SUM_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q} <<< FRAC_BITS;
      half     = '0;
      half[FRAC_BITS-1] = 1'b1;
      sum      = acc_ext + bias_ext + half;
      shifted  = sum >>> FRAC_BITS;
      hi_pos   = ~shifted[SUM_WIDTH-1] && (shifted[SUM_WIDTH-1:DATA_WIDTH-1] != '0);
      hi_neg   =  shifted[SUM_WIDTH-1] && (shifted[SUM_WIDTH-1:DATA_WIDTH-1] != '1);
      sat_c    = hi_pos || hi_neg;
      if (hi_pos)
         res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (hi_neg)
         res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
         res = shifted[DATA_WIDTH-1:0];
      if (relu_q && res[DATA_WIDTH-1])
         res = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         bias_q    <= '0;
         relu_q    <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_ovf   <= 1'b0;
         out_taps  <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid && in_ready) begin
                  acc <= acc + prod_ext;
                  // Extra taps beyond the limit still accumulate; only the count saturates.
                  if (cnt == MAX_CNT)
                     ovf <= 1'b1;
                  else
                     cnt <= cnt + CNT_WIDTH'(1);
                  if (in_last) begin
                     bias_q <= cfg_bias;
                     relu_q <= cfg_relu;
                     state  <= ROUND;
                  end
               end
            end
            ROUND: begin
               out_data  <= res;
               out_sat   <= sat_c;
               out_ovf   <= ovf;
               out_taps  <= cnt;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_qconv_mac_engine.sv
// tb/tb_qconv_mac_engine.sv - scoreboard bench for qconv_mac_engine
module tb_qconv_mac_engine;

   localparam int DW = 16;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_x;
   logic [DW-1:0] in_w;
   logic          in_last;
   logic [DW-1:0] cfg_bias;
   logic          cfg_relu;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_sat;
   logic          out_ovf;
   logic [CW-1:0] out_taps;

   typedef struct {
      logic [DW-1:0] data;
      logic          sat;
      logic          ovf;
      logic [CW-1:0] taps;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   spurious = 0;

   qconv_mac_engine #(.DATA_WIDTH(16), .FRAC_BITS(8), .MAX_TAPS(72)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_w(in_w), .in_last(in_last), .cfg_bias(cfg_bias),
      .cfg_relu(cfg_relu), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .out_ovf(out_ovf), .out_taps(out_taps)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input longint acc, input int n, input logic [DW-1:0] bias,
                                  input logic relu);
      exp_t   e;
      longint s;
      longint r;
      s = acc + longint'($signed(bias)) * 256 + 128;
      r = s >>> 8;
      e.sat = 1'b0;
      if (r > 32767) begin r = 32767; e.sat = 1'b1; end
      if (r < -32768) begin r = -32768; e.sat = 1'b1; end
      if (relu && r < 0) r = 0;
      e.data = DW'(r);
      e.ovf  = (n > 72);
      e.taps = CW'((n > 72) ? 72 : n);
      return e;
   endfunction

   task automatic push_exp(input logic [DW-1:0] d, input logic s, input logic o, input int t);
      exp_t e;
      e.data = d; e.sat = s; e.ovf = o; e.taps = CW'(t);
      sbq.push_back(e);
   endtask

   // Drives n beats; cfg values are randomised except on the final beat, where they are sampled.
   task automatic drive(input int n, input logic [DW-1:0] x0, input logic [DW-1:0] w0,
                        input logic [DW-1:0] bias, input logic relu, input bit rnd,
                        input bit with_last, output longint acc);
      logic [DW-1:0] x;
      logic [DW-1:0] w;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         if (rnd && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            in_x = DW'($urandom); in_w = DW'($urandom); in_last = 1'b1;
            @(posedge clk); #1;
         end
         x = rnd ? DW'($urandom) : x0;
         w = rnd ? DW'($urandom) : w0;
         acc += longint'($signed(x)) * longint'($signed(w));
         in_valid = 1'b1; in_x = x; in_w = w;
         in_last  = with_last && (i == n-1);
         cfg_bias = in_last ? bias : DW'($urandom);
         cfg_relu = in_last ? relu : 1'($urandom);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_x = DW'($urandom); in_w = DW'($urandom); in_last = 1'($urandom);
      cfg_bias = DW'($urandom); cfg_relu = 1'($urandom);
   endtask

   // Waits for the result, checks latency/fields/backpressure, then completes the handshake.
   task automatic collect(input string name, input int hold_cycles);
      int   lat;
      exp_t e;
      logic [DW-1:0] d0;
      lat = 0;
      out_ready = (hold_cycles == 0);
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
         return;
      end
      total++;
      if (lat != 2) begin bad++; $display("FAIL %s latency: got %0d required 2", name, lat); end
      total++;
      if (spurious != 0) begin
         bad++; $display("FAIL %s beat_phase: %0d bad in_ready/out_valid samples required 0", name, spurious);
      end
      spurious = 0;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL %s hold_in_ready: got %b required 0", name, in_ready); end
      total++;
      if (sbq.size() == 0) begin
         bad++; $display("FAIL %s scoreboard: got empty queue required 1 entry", name);
      end else begin
         e = sbq.pop_front();
         if (out_data !== e.data || out_sat !== e.sat || out_ovf !== e.ovf || out_taps !== e.taps) begin
            bad++;
            $display("FAIL %s result: got data=%h sat=%b ovf=%b taps=%0d required data=%h sat=%b ovf=%b taps=%0d",
                     name, out_data, out_sat, out_ovf, out_taps, e.data, e.sat, e.ovf, e.taps);
         end
      end
      d0 = out_data;
      for (int i = 0; i < hold_cycles; i++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0 || out_taps !== e.taps) begin
            bad++;
            $display("FAIL %s stall_%0d: got valid=%b ready=%b data=%h required valid=1 ready=0 data=%h",
                     name, i, out_valid, in_ready, out_data, d0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s release: got valid=%b ready=%b required valid=0 ready=1", name, out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_w = '0; in_last = 1'b0;
      cfg_bias = '0; cfg_relu = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 ||
          out_ovf !== 1'b0 || out_taps !== '0) begin
         bad++;
         $display("FAIL reset_state: got ready=%b valid=%b data=%h sat=%b ovf=%b taps=%0d required 1 0 0000 0 0 0",
                  in_ready, out_valid, out_data, out_sat, out_ovf, out_taps);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      longint a;
      push_exp(16'h04C0, 1'b0, 1'b0, 9);
      drive(9, 16'h0100, 16'h0080, 16'h0040, 1'b0, 1'b0, 1'b1, a);
      collect("basic9", 0);
   endtask

   task automatic test_round_half();
      longint a;
      push_exp(16'h0001, 1'b0, 1'b0, 1);
      drive(1, 16'h0001, 16'h0080, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("round_half", 0);
   endtask

   task automatic test_saturation();
      longint a;
      push_exp(16'h7FFF, 1'b1, 1'b0, 4);
      drive(4, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("sat_pos", 0);
      push_exp(16'h8000, 1'b1, 1'b0, 4);
      drive(4, 16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("sat_neg", 0);
   endtask

   task automatic test_relu();
      longint a;
      push_exp(16'hFF00, 1'b0, 1'b0, 1);
      drive(1, 16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("relu_off", 0);
      push_exp(16'h0000, 1'b0, 1'b0, 1);
      drive(1, 16'h0100, 16'hFF00, 16'h0000, 1'b1, 1'b0, 1'b1, a);
      collect("relu_on", 0);
   endtask

   task automatic test_backpressure();
      longint a;
      push_exp(16'h4900, 1'b0, 1'b1, 72);
      drive(73, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("ovf73_stall", 5);
   endtask

   task automatic test_reset_mid();
      longint a;
      drive(4, 16'h0100, 16'h0080, 16'h0040, 1'b0, 1'b0, 1'b0, a);
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_mid_pulse: got valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) spurious++;
      end
      @(posedge clk); #1;
      push_exp(16'h04C0, 1'b0, 1'b0, 9);
      drive(9, 16'h0100, 16'h0080, 16'h0040, 1'b0, 1'b0, 1'b1, a);
      collect("reset_mid", 0);
   endtask

   task automatic test_reset_hold();
      longint a;
      int     n;
      drive(5, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      out_ready = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_taps !== '0 || out_data !== '0) begin
         bad++;
         $display("FAIL reset_hold_drop: got valid=%b taps=%0d data=%h required 0 0 0000", out_valid, out_taps, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      push_exp(16'h0100, 1'b0, 1'b0, 1);
      drive(1, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, a);
      collect("reset_hold_fresh", 0);
   endtask

   task automatic test_back_to_back();
      longint        a;
      int            n;
      logic [DW-1:0] bias;
      logic          relu;
      for (int k = 0; k < 6; k++) begin
         n    = $urandom_range(1, 10);
         bias = DW'($urandom);
         relu = 1'($urandom);
         drive(n, 16'h0000, 16'h0000, bias, relu, 1'b1, 1'b1, a);
         sbq.push_back(model(a, n, bias, relu));
         collect($sformatf("random_%0d", k), (k % 2) * 3);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_half();
      test_saturation();
      test_relu();
      test_backpressure();
      test_reset_mid();
      test_reset_hold();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached required completion");
      $fatal(1, "watchdog");
   end

endmodule
